// File: rtl/feet_to_meters_conv_pkg.sv
// Shared constants and state encoding for the feet/meters conversion blocks.
// Conversion constants are Q0.16 (meters->feet uses integer bits too).
package conv_pkg;

    localparam int DEF_DATA_W = 24;
    localparam int DEF_FRAC_W = 8;
    localparam int DEF_K_W    = 16;

    localparam int K_FT2M_Q16 = 19975;   // round(0.3048 * 2^16)
    localparam int K_M2FT_Q16 = 215011;  // round(3.2808 * 2^16), paired block

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/feet_to_meters_conv_if.sv
// Operand/result handshake bundle for the feet-to-meters converter.
interface feet_to_meters_conv_if
    import conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_feet;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_meters;
  logic              busy;

  modport master (
    output in_valid, in_feet, out_ready,
    input  in_ready, out_valid, out_meters, busy
  );

  modport slave (
    input  in_valid, in_feet, out_ready,
    output in_ready, out_valid, out_meters, busy
  );
endinterface

// File: rtl/feet_to_meters_conv_shift_add_mult.sv
// Sequential unsigned shift-add multiplier, one multiplier bit per clock.
// done/product are combinational on the final step so the caller can latch in the same edge.
module shift_add_mult #(
  parameter int A_W = 24,
  parameter int B_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               done,
  output logic [A_W+B_W-1:0] product
);
  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = $clog2(B_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(B_W - 1);

  logic [P_W-1:0]   mcand_reg;
  logic [B_W-1:0]   mplier_reg;
  logic [P_W-1:0]   acc_reg;
  logic [P_W-1:0]   acc_next;
  logic [CNT_W-1:0] count_reg;
  logic             run_reg;

  assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign done     = run_reg && (count_reg == LAST);
  assign product  = acc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
      run_reg    <= 1'b0;
    end else if (start) begin
      mcand_reg  <= P_W'(a);
      mplier_reg <= b;
      acc_reg    <= '0;
      count_reg  <= '0;
      run_reg    <= 1'b1;
    end else if (run_reg) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      count_reg  <= count_reg + 1'b1;
      if (done)
        run_reg <= 1'b0;
    end
  end
endmodule

// File: rtl/feet_to_meters_conv.sv
// Feet -> meters converter: handshake FSM around a shift-add multiply by 0.3048,
// with round-half-up back to the input fixed-point format.
module feet_to_meters_conv
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int K_W    = DEF_K_W,
  parameter int K_FT2M = K_FT2M_Q16
) (
  input logic                 clk,
  input logic                 rst,
  feet_to_meters_conv_if.slave bus
);
  localparam int P_W = DATA_W + K_W;
  localparam logic [P_W-1:0] HALF = P_W'(1) << (K_W - 1);

  if (FRAC_W >= DATA_W) begin : g_bad_frac
    $error("FRAC_W must be smaller than DATA_W");
  end

  state_t            state_reg;
  state_t            state_next;
  logic              mult_start;
  logic              mult_done;
  logic [P_W-1:0]    product;
  logic [DATA_W-1:0] rounded;
  logic [DATA_W-1:0] meters_reg;

  shift_add_mult #(
    .A_W (DATA_W),
    .B_W (K_W)
  ) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (mult_start),
    .a       (bus.in_feet),
    .b       (K_W'(K_FT2M)),
    .done    (mult_done),
    .product (product)
  );

  // Constant is below 1.0, so the rounded quotient always fits DATA_W.
  assign rounded = DATA_W'((product + HALF) >> K_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    mult_start = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          mult_start = 1'b1;
          state_next = CALC;
        end
      end
      CALC: if (mult_done) state_next = DONE;
      DONE: if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      meters_reg <= '0;
    else if (state_reg == CALC && mult_done)
      meters_reg <= rounded;
  end

  assign bus.in_ready   = (state_reg == IDLE);
  assign bus.out_valid  = (state_reg == DONE);
  assign bus.busy       = (state_reg != IDLE);
  assign bus.out_meters = meters_reg;
endmodule

// File: tb/tb_feet_to_meters_conv.sv
// Directed bench for feet_to_meters_conv: an arithmetic/timing model checked
// every cycle, plus literal expectations for the documented vectors.
module tb_feet_to_meters_conv;
  import conv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  feet_to_meters_conv_if #(.DATA_W(24)) bus ();

  feet_to_meters_conv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // meters = round_half_up(feet * 0.3048) using the Q0.16 constant
  function automatic logic [23:0] ft2m(input logic [23:0] feet);
    longint p;
    p = longint'(feet) * 64'd19975 + 64'd32768;
    return 24'(p / 65536);
  endfunction

  // ---------------- reference model, compared on every falling edge ----------------
  bit          m_busy, m_valid;
  int          m_left;
  logic [23:0] m_out, m_res, m_feet;
  int          n_txn = 0;

  initial begin
    m_busy = 0; m_valid = 0; m_left = 0; m_out = '0; m_res = '0; m_feet = '0;
  end

  always @(negedge clk) begin
    if (rst) begin
      m_busy = 0; m_valid = 0; m_left = 0; m_out = '0;
    end
    chk("in_ready",   32'(bus.in_ready),   32'(!m_busy));
    chk("out_valid",  32'(bus.out_valid),  32'(m_valid));
    chk("busy",       32'(bus.busy),       32'(m_busy));
    chk("out_meters", 32'(bus.out_meters), 32'(m_out));
    if (!rst) begin
      // predict the effect of the coming rising edge
      if (!m_busy) begin
        if (bus.in_valid) begin
          m_busy = 1; m_left = 16; m_feet = bus.in_feet; m_res = ft2m(bus.in_feet);
        end
      end else if (!m_valid) begin
        m_left--;
        if (m_left == 0) begin
          m_valid = 1; m_out = m_res;
        end
      end else if (bus.out_ready) begin
        n_txn++;
        $display("txn %0d: feet=0x%06h meters=0x%06h (%0d)", n_txn, m_feet, bus.out_meters, bus.out_meters);
        m_valid = 0; m_busy = 0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic conv(input logic [23:0] feet, input logic [23:0] exp, input string name);
    int lat;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_feet  = feet;
    @(posedge clk); #1;           // accepting edge
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'd16);
    chk({name, "_meters"},  32'(bus.out_meters), 32'(exp));
    @(posedge clk); #1;           // handshake (out_ready held high)
  endtask

  initial begin
    int lat;
    logic [23:0] held;
    bus.in_valid  = 1'b0;
    bus.in_feet   = '0;
    bus.out_ready = 1'b1;

    #1;
    chk("rst_in_ready",   32'(bus.in_ready),   32'd1);
    chk("rst_out_valid",  32'(bus.out_valid),  32'd0);
    chk("rst_out_meters", 32'(bus.out_meters), 32'd0);
    chk("rst_busy",       32'(bus.busy),       32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // model pinning against hand-computed values
    chk("model_1ft",  32'(ft2m(24'd256)),      32'd78);
    chk("model_max",  32'(ft2m(24'hFFFFFF)),   32'h4E0700);

    conv(24'd256,     24'd78,      "one_ft");
    conv(24'd2560,    24'd780,     "ten_ft");
    conv(24'd840,     24'd256,     "round_trip");
    conv(24'd0,       24'd0,       "zero");
    conv(24'hFFFFFF,  24'h4E0700,  "all_ones");
    chk("retain_after_hs", 32'(bus.out_meters), 32'h4E0700);

    // backpressure: result held while a second operand waits
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_feet = 24'd2560;
    @(posedge clk); #1;
    bus.in_feet = 24'd256;        // next operand, presented while busy
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk("bp_latency", 32'(lat), 32'd16);
    held = bus.out_meters;
    chk("bp_meters", 32'(held), 32'd780);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid_hold",  32'(bus.out_valid),  32'd1);
      chk("bp_meters_hold", 32'(bus.out_meters), 32'(held));
      chk("bp_in_ready",    32'(bus.in_ready),   32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;           // output handshake edge
    chk("bp_hs_valid",    32'(bus.out_valid), 32'd0);
    chk("bp_hs_in_ready", 32'(bus.in_ready),  32'd1);
    @(posedge clk); #1;           // second operand accepted here
    chk("bp_accept", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk("bp2_latency", 32'(lat), 32'd16);
    chk("bp2_meters",  32'(bus.out_meters), 32'd78);
    @(posedge clk); #1;

    // reset in the middle of a conversion (count = 7)
    bus.in_valid = 1'b1; bus.in_feet = 24'd2560;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_in_ready",   32'(bus.in_ready),   32'd1);
    chk("midrst_out_valid",  32'(bus.out_valid),  32'd0);
    chk("midrst_out_meters", 32'(bus.out_meters), 32'd0);
    chk("midrst_busy",       32'(bus.busy),       32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) lat++;
    end
    chk("midrst_no_valid", 32'(lat), 32'd0);
    conv(24'd256, 24'd78, "after_rst");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
